led_breath_ctrl: RTL

Sequencing controller for the 4-channel LED PWM path on the 50 MHz board clock. It accepts per-channel mode commands over a valid/ready handshake and runs one shared duty-ramp engine (ramp up, hold, ramp down, hold). It drives `pio_led[3:0]` directly with per-channel OFF, ON or breathing waveforms. It replaces free-running breathing logic wherever software or other blocks must choose which LEDs breathe.

---
 rtl/led_ctrl_pkg.sv | 17 +
 rtl/pwm_timebase.sv | 30 +++
 rtl/led_breath_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode codes, ramp state encodings and channel count for the LED breathing controller.
package led_ctrl_pkg;
  localparam int NUM_CH = 4;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_SINGLE  = 2'd3
  } mode_e;
  typedef enum logic [2:0] {
    R_IDLE    = 3'd0,
    R_UP      = 3'd1,
    R_HOLD_HI = 3'd2,
    R_DOWN    = 3'd3,
    R_HOLD_LO = 3'd4
  } ramp_e;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: microsecond prescaler, PWM period counter and one-clk period wrap strobe.
module pwm_timebase #(
  parameter int CLK_PER_US = 50,
  parameter int PWM_PERIOD = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [$clog2(PWM_PERIOD+1)-1:0]   pcnt_o,
  output logic                              strobe_o
);
  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int PSW = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
  localparam logic [PSW-1:0] PRE_LAST = PSW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] PCNT_LAST = CW'(PWM_PERIOD - 1);
  logic [PSW-1:0] pre_q;
  logic [CW-1:0] pcnt_q;
  logic tick;
  assign tick = pre_q == PRE_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      pcnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) pcnt_q <= pcnt_q == PCNT_LAST ? '0 : pcnt_q + 1'b1;
    end
  end
  assign pcnt_o   = pcnt_q;
  assign strobe_o = tick && pcnt_q == PCNT_LAST;
endmodule

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl: per-channel OFF/ON/BREATHE/SINGLE LED sequencer sharing one duty-ramp engine.
// LED_GAMMA_EN: when defined, eff_duty = duty^2/PWM_PERIOD registered; otherwise eff_duty = duty.
module led_breath_ctrl import led_ctrl_pkg::*; #(
  parameter int CLK_PER_US   = 50,
  parameter int PWM_PERIOD   = 1000,
  parameter int RAMP_STEP    = 1,
  parameter int HOLD_PERIODS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_mask,
  output logic       busy,
  output logic       period_strobe,
  output logic [3:0] pio_led
);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int HW = HOLD_PERIODS > 1 ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [DW-1:0] DMAX = DW'(PWM_PERIOD);
  localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);
  localparam logic [DW-1:0] UP_LIM = DW'(PWM_PERIOD - RAMP_STEP);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_PERIODS - 1);
  logic strobe, active, revert;
  logic [DW-1:0] pcnt, eff_duty, duty_q, duty_d;
  logic [HW-1:0] hold_q, hold_d;
  ramp_e state_q, state_d;
  mode_e [NUM_CH-1:0] mode_q, mode_d;
  mode_e pmode_q, pmode_d;
  logic [NUM_CH-1:0] pmask_q, pmask_d, led_q, led_d;
  logic pend_q, pend_d;
  pwm_timebase #(.CLK_PER_US(CLK_PER_US), .PWM_PERIOD(PWM_PERIOD)) u_tb (
    .clk(clk), .rst(rst), .pcnt_o(pcnt), .strobe_o(strobe)
  );
`ifdef LED_GAMMA_EN
  logic [DW-1:0] eff_q;
  logic [2*DW-1:0] sq;
  assign sq = {{DW{1'b0}}, duty_q} * {{DW{1'b0}}, duty_q};
  always_ff @(posedge clk) begin
    if (rst) eff_q <= '0;
    else eff_q <= DW'(sq / (2*DW)'(PWM_PERIOD));
  end
  assign eff_duty = eff_q;
`else
  assign eff_duty = duty_q;
`endif
  always_comb begin
    pend_d  = pend_q;
    pmode_d = pmode_q;
    pmask_d = pmask_q;
    mode_d  = mode_q;
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    active  = 1'b0;
    revert  = 1'b0;
    if (strobe && pend_q) begin
      for (int i = 0; i < NUM_CH; i++) if (pmask_q[i]) mode_d[i] = pmode_q;
      pend_d = 1'b0;
    end
    if (cmd_valid && !pend_q) begin
      pend_d  = 1'b1;
      pmode_d = mode_e'(cmd_mode);
      pmask_d = cmd_mask;
    end
    // The ramp sees the active set as it stands after this strobe's command.
    for (int i = 0; i < NUM_CH; i++)
      active = active | (mode_d[i] == MODE_BREATHE) | (mode_d[i] == MODE_SINGLE);
    if (strobe) begin
      if (!active) begin
        state_d = R_IDLE;
        duty_d  = '0;
      end else begin
        case (state_q)
          R_IDLE: begin
            state_d = R_UP;
            duty_d  = '0;
          end
          R_UP: begin
            duty_d = duty_q >= UP_LIM ? DMAX : duty_q + STEP;
            if (duty_d == DMAX) begin
              hold_d  = '0;
              state_d = R_HOLD_HI;
            end
          end
          R_HOLD_HI: begin
            state_d = hold_q == HLAST ? R_DOWN : R_HOLD_HI;
            hold_d  = hold_q + 1'b1;
          end
          R_DOWN: begin
            duty_d = duty_q <= STEP ? '0 : duty_q - STEP;
            if (duty_d == '0) begin
              hold_d  = '0;
              state_d = R_HOLD_LO;
              revert  = 1'b1;
            end
          end
          R_HOLD_LO: begin
            state_d = hold_q == HLAST ? R_UP : R_HOLD_LO;
            hold_d  = hold_q + 1'b1;
          end
          default: state_d = R_IDLE;
        endcase
      end
    end
    // A command landing on the same strobe overrides the SINGLE revert.
    for (int i = 0; i < NUM_CH; i++)
      if (revert && !(pend_q && pmask_q[i]) && mode_d[i] == MODE_SINGLE) mode_d[i] = MODE_OFF;
    for (int i = 0; i < NUM_CH; i++)
      led_d[i] = mode_q[i] == MODE_OFF ? 1'b0 : mode_q[i] == MODE_ON ? 1'b1 : pcnt < eff_duty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      pmode_q <= MODE_OFF;
      pmask_q <= '0;
      mode_q  <= {NUM_CH{MODE_OFF}};
      state_q <= R_IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      led_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      pmode_q <= pmode_d;
      pmask_q <= pmask_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end
  assign cmd_ready     = !pend_q;
  assign busy          = state_q != R_IDLE || pend_q;
  assign period_strobe = strobe;
  assign pio_led       = led_q;
endmodule
